// File: rtl/x_load_packer.sv
// x_load_packer: registers the pad inputs, detects a frame start edge,
// and packs incoming bytes little-endian into memory words.
module x_load_packer #(
  parameter int DATA_W  = 8,
  parameter int PACK    = 4,
  parameter int N_BYTES = 64,
  parameter int ADDR_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_in,
  input  logic                     valid_input,
  input  logic [DATA_W-1:0]        X_load,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W*PACK-1:0]   wr_data,
  output logic                     busy,
  output logic                     load_done
);

  localparam int BCW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [BCW-1:0] LAST_BYTE =
    BCW'(PACK - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD =
    ADDR_W'(N_BYTES / PACK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic              in_start_q;
  logic              in_start_d_q;
  logic              in_valid_q;
  logic [DATA_W-1:0] in_byte_q;

  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;

  logic [PACK-2:0][DATA_W-1:0] lane_q, lane_d;

  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W*PACK-1:0] wr_data_q, wr_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic start_pulse;
  logic last_byte;
  logic last_word;

  // A start edge coinciding with the done pulse is not a new frame.
  assign start_pulse = in_start_q & ~in_start_d_q & ~done_q;
  assign last_byte   = (byte_cnt_q == LAST_BYTE);
  assign last_word   = (word_cnt_q == LAST_WORD);

  // Pad input capture and start edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_start_q   <= 1'b0;
      in_start_d_q <= 1'b0;
      in_valid_q   <= 1'b0;
      in_byte_q    <= '0;
    end else begin
      in_start_q   <= start_in;
      in_start_d_q <= in_start_q;
      in_valid_q   <= valid_input;
      in_byte_q    <= X_load;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave LOAD only on the final byte of the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_pulse) state_d = LOAD;
      LOAD: begin
        if (in_valid_q && last_byte && last_word) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next state.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    lane_d     = lane_q;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start_pulse) begin
          byte_cnt_d = '0;
          word_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      LOAD: begin
        if (in_valid_q) begin
          if (!last_byte) begin
            lane_d[byte_cnt_q] = in_byte_q;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end else begin
            wr_en_d    = 1'b1;
            wr_addr_d  = word_cnt_q;
            wr_data_d  = {in_byte_q, lane_q};
            byte_cnt_d = '0;
            word_cnt_d = word_cnt_q + 1'b1;
            if (last_word) begin
              word_cnt_d = '0;
              done_d     = 1'b1;
              busy_d     = 1'b0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      lane_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      lane_q     <= lane_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign load_done = done_q;

endmodule

// File: tb/tb_x_load_packer.sv
// tb_x_load_packer: directed frames with a write scoreboard
// checked by an independent monitor on the falling edge.
module tb_x_load_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b0;
  logic        valid_input = 1'b0;
  logic [7:0]  X_load = '0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        load_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wr = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        done;
    int          gap;
  } exp_t;

  exp_t exp_q[$];

  x_load_packer dut (
    .clk(clk),
    .rst(rst),
    .start_in(start_in),
    .valid_input(valid_input),
    .X_load(X_load),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr got addr=%0d data=%h want none",
                 wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
        chk("load_done", 64'(load_done), 64'(e.done));
        chk("busy_at_wr", 64'(busy), 64'(!e.done));
        if (e.gap != 0) begin
          chk("wr_gap", 64'(cyc - last_wr), 64'(e.gap));
        end
      end
      last_wr = cyc;
    end else if (rst && load_done) begin
      checks++;
      failures++;
      $display("FAIL stray_done got=1 want=0");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wexp(int b, int w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = 8'(b + 4*w + k);
    end
    return r;
  endfunction

  task automatic push_frame(input int base, input int gap,
                            input int nwords);
    exp_t e;
    for (int w = 0; w < nwords; w++) begin
      e.addr = 4'(w);
      e.data = wexp(base, w);
      e.done = (w == 15);
      e.gap  = (w == 0) ? 0 : gap;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_frame(input bit hold);
    start_in = 1'b1;
    step();
    start_in = hold;
    repeat (3) step();
    chk("busy_start", 64'(busy), 64'd1);
  endtask

  task automatic stream(input int base, input int n,
                        input bit gapped, input int start_at,
                        input bit hold);
    for (int i = 0; i < n; i++) begin
      X_load      = 8'(base + i);
      valid_input = 1'b1;
      start_in    = hold | (i == start_at + 1);
      step();
      if (gapped) begin
        valid_input = 1'b0;
        step();
      end
    end
    valid_input = 1'b0;
    start_in    = hold;
  endtask

  task automatic finish_frame(input string nm);
    repeat (6) step();
    chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    // 1: reset with toggling inputs, then idle with valid data
    #3 rst = 1'b0;
    #1;
    chk("rst_async", 64'({wr_en, wr_addr, wr_data, busy, load_done}), 64'd0);
    for (int i = 0; i < 6; i++) begin
      start_in    = 1'($urandom);
      valid_input = 1'($urandom);
      X_load      = 8'($urandom);
      @(negedge clk);
      chk("rst_outs", 64'({wr_en, wr_addr, wr_data, busy, load_done}), 64'd0);
    end
    start_in    = 1'b0;
    valid_input = 1'b0;
    step();
    rst = 1'b1;
    valid_input = 1'b1;
    X_load = 8'hAA;
    repeat (20) step();
    chk("idle_busy", 64'(busy), 64'd0);
    valid_input = 1'b0;
    step();

    // 2: full frame, continuous stream
    push_frame(8'h00, 4, 16);
    start_frame(1'b0);
    stream(8'h00, 64, 1'b0, -2, 1'b0);
    finish_frame("full");

    // 3: valid toggling every cycle
    push_frame(8'h10, 8, 16);
    start_frame(1'b0);
    stream(8'h10, 64, 1'b1, -2, 1'b0);
    finish_frame("gapped");

    // 4: start held high, then a fresh edge
    push_frame(8'h40, 4, 16);
    start_frame(1'b1);
    stream(8'h40, 64, 1'b0, -2, 1'b1);
    X_load = 8'hEE;
    valid_input = 1'b1;
    repeat (20) step();
    valid_input = 1'b0;
    finish_frame("held");
    start_in = 1'b0;
    repeat (3) step();
    push_frame(8'h80, 4, 16);
    start_frame(1'b0);
    stream(8'h80, 64, 1'b0, -2, 1'b0);
    finish_frame("retrig");

    // 5: reset mid-frame
    push_frame(8'h20, 4, 1);
    start_frame(1'b0);
    stream(8'h20, 6, 1'b0, -2, 1'b0);
    repeat (4) step();
    chk("mid_word0", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst", 64'({wr_en, busy, load_done}), 64'd0);
    step();
    rst = 1'b1;
    stream(8'h26, 20, 1'b0, -2, 1'b0);
    finish_frame("mid_quiet");
    push_frame(8'hC0, 4, 16);
    start_frame(1'b0);
    stream(8'hC0, 64, 1'b0, -2, 1'b0);
    finish_frame("mid_clean");

    // 6: start pulse during LOAD
    push_frame(8'h00, 4, 16);
    start_frame(1'b0);
    stream(8'h00, 64, 1'b0, 10, 1'b0);
    finish_frame("ld_start");
    repeat (10) step();
    chk("ld_start_none", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
